imem_loader: RTL and testbench

- Writer side of the instruction memory.
- Accepts a framed byte stream from a host link and assembles it into 32-bit big-endian instruction words.
- Issues single-cycle word writes into the instruction RAM that the fetch stage reads at word index addr[7:2].
- Holds the CPU in reset while a program is loading, and reports completion or a framing/checksum error.

---
 rtl/imem_loader.sv | 201 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a framed host byte stream into big-endian
// 32-bit words, writes them to the instruction RAM and holds the CPU meanwhile.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        clear,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [31:0] BASE_ALIGNED = {BASE_ADDR[31:2], 2'b00};
  localparam logic [15:0] MAX_WORDS    = 16'(DEPTH_WORDS);

  state_e      state_q;
  logic        in_ready_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        cpu_hold_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] words_written_q;
  logic [7:0]  acc_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  cnt_hi_q;
  logic [15:0] count_q;
  logic [15:0] words_asm_q;
  logic [23:0] asm_q;

  logic        xfer;
  logic [15:0] count_d;
  logic [31:0] word_d;
  logic [7:0]  acc_d;

  assign xfer    = in_valid && in_ready_q;
  assign count_d = {cnt_hi_q, in_data};
  assign word_d  = {asm_q, in_data};
  assign acc_d   = acc_q ^ in_data;

  // NOTE: every register here is written with <= so all branches see the
  // pre-edge values; a blocking write would leak into later branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      in_ready_q      <= 1'b1;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= BASE_ALIGNED;
      mem_wdata_q     <= 32'd0;
      cpu_hold_q      <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      words_written_q <= 16'd0;
      acc_q           <= 8'd0;
      byte_idx_q      <= 2'd0;
      // NOTE: datapath-only registers are reset too so a reloaded frame never
      // observes bytes left over from an aborted one.
      cnt_hi_q        <= 8'd0;
      count_q         <= 16'd0;
      words_asm_q     <= 16'd0;
      asm_q           <= 24'd0;
    end else begin
      mem_we_q <= 1'b0;

      // Post-write bookkeeping; the address stays on the last written word
      // once the frame's final word has gone out.
      if (mem_we_q) begin
        words_written_q <= words_written_q + 16'd1;
        if (words_written_q + 16'd1 < count_q) begin
          mem_addr_q <= mem_addr_q + 32'd4;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (xfer && in_data == SYNC_BYTE) begin
            acc_q           <= 8'd0;
            byte_idx_q      <= 2'd0;
            words_written_q <= 16'd0;
            words_asm_q     <= 16'd0;
            mem_addr_q      <= BASE_ALIGNED;
            cpu_hold_q      <= 1'b1;
            state_q         <= S_CNT_HI;
          end
        end

        S_CNT_HI: begin
          if (xfer) begin
            cnt_hi_q <= in_data;
            acc_q    <= acc_d;
            state_q  <= S_CNT_LO;
          end
        end

        S_CNT_LO: begin
          if (xfer) begin
            count_q <= count_d;
            acc_q   <= acc_d;
            if (count_d > MAX_WORDS) begin
              err_q      <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= S_ERR;
            end else if (count_d == 16'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            acc_q      <= acc_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            asm_q      <= {asm_q[15:0], in_data};
            if (byte_idx_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= word_d;
              words_asm_q <= words_asm_q + 16'd1;
              if (words_asm_q + 16'd1 == count_q) begin
                state_q <= S_CHK;
              end
            end
          end
        end

        S_CHK: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (in_data == acc_q) begin
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
              state_q    <= S_DONE;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end

        S_DONE: begin
          if (clear) begin
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end

        S_ERR: begin
          if (clear) begin
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = words_written_q;

  a_we_single_cycle : assert property (@(posedge clk) disable iff (rst)
    mem_we_q |=> !mem_we_q);

  a_done_err_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(done_q && err_q));

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame table plus hand-written corner
// sequences; RAM writes are matched against a scoreboard of expected writes.
module tb_imem_loader;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [7:0]  SYNC  = 8'hA5;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        clear;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  imem_loader #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .clear         (clear),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    bit          bad;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    logic [15:0] exp_ww;
    bit          exp_hold;
  } frame_vec_t;

  wr_t        sb[$];
  frame_vec_t vecs[7];
  int         n_vec;
  int         n_miss;
  logic       prev_we;
  logic [7:0] chk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      check("we_back_to_back", 64'(prev_we), 64'd0);
      check("hold_during_write", 64'(cpu_hold), 64'd1);
      if (sb.size() == 0) begin
        check("we_unexpected", 64'(mem_we), 64'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
    prev_we = mem_we;
  end

  // Tasks are entered and left 1 ns after a rising edge with in_valid low.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    for (int k = 0; k < 6 && gaps && ($urandom_range(1, 0) == 1); k++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input bit gaps,
                           inout logic [7:0] acc);
    for (int j = 3; j >= 0; j--) begin
      acc = acc ^ w[8*j +: 8];
      if (j == 0) sb.push_back('{addr: BASE + 32'(4 * idx), data: w});
      send_byte(w[8*j +: 8], gaps);
    end
  endtask

  task automatic send_header(input logic [15:0] n, input bit gaps, output logic [7:0] acc);
    send_byte(SYNC, gaps);
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    acc = n[15:8] ^ n[7:0];
  endtask

  task automatic run_frame(input logic [15:0] n, input bit bad, input bit gaps);
    logic [7:0] acc;
    send_header(n, gaps, acc);
    for (int i = 0; i < int'(n); i++) send_word($urandom, i, gaps, acc);
    send_byte(bad ? (acc ^ 8'h5A) : acc, gaps);
  endtask

  task automatic finish_frame(input string tag, input bit e_done, input bit e_err,
                              input logic [15:0] e_ww, input bit e_hold);
    for (int i = 0; i < 16 && sb.size() != 0; i++) @(negedge clk);
    check({tag, "_sb_drain"}, 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(e_done));
    check({tag, "_err"}, 64'(err), 64'(e_err));
    check({tag, "_words"}, 64'(words_written), 64'(e_ww));
    check({tag, "_hold"}, 64'(cpu_hold), 64'(e_hold));
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check({tag, "_clr_done"}, 64'(done), 64'd0);
    check({tag, "_clr_err"}, 64'(err), 64'd0);
    check({tag, "_clr_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_clr_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_we"}, 64'(mem_we), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'(BASE));
    check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_words"}, 64'(words_written), 64'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{n: 16'd1,  bad: 1'b0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_ww: 16'd1,  exp_hold: 1'b0};
    vecs[1] = '{n: 16'd3,  bad: 1'b0, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_ww: 16'd3,  exp_hold: 1'b0};
    vecs[2] = '{n: 16'd0,  bad: 1'b0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_ww: 16'd0,  exp_hold: 1'b0};
    vecs[3] = '{n: 16'd64, bad: 1'b0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_ww: 16'd64, exp_hold: 1'b0};
    vecs[4] = '{n: 16'd5,  bad: 1'b1, gaps: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_ww: 16'd5,  exp_hold: 1'b1};
    vecs[5] = '{n: 16'd2,  bad: 1'b0, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_ww: 16'd2,  exp_hold: 1'b0};
    vecs[6] = '{n: 16'd64, bad: 1'b0, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_ww: 16'd64, exp_hold: 1'b0};

    n_vec    = 0;
    n_miss   = 0;
    prev_we  = 1'b0;
    clk      = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;

    // clear while IDLE has no effect
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("idle_clear_ready", 64'(in_ready), 64'd1);
    check("idle_clear_hold", 64'(cpu_hold), 64'd0);
    @(posedge clk);
    #1;

    // Two-word program behind a discarded leading byte; its XOR checksum is 0x30.
    send_byte(8'h00, 1'b0);
    check("junk_hold", 64'(cpu_hold), 64'd0);
    send_header(16'd2, 1'b0, chk);
    check("sync_hold", 64'(cpu_hold), 64'd1);
    send_word(32'h0800_001D, 0, 1'b0, chk);
    send_word(32'h2008_000F, 1, 1'b0, chk);
    send_byte(chk, 1'b0);
    finish_frame("plan_ok", 1'b1, 1'b0, 16'd2, 1'b0);
    do_clear("plan_ok");

    // Same program closed with 0x4F, which differs from 0x30.
    send_header(16'd2, 1'b0, chk);
    send_word(32'h0800_001D, 0, 1'b0, chk);
    send_word(32'h2008_000F, 1, 1'b0, chk);
    send_byte(8'h4F, 1'b0);
    finish_frame("plan_bad", 1'b0, 1'b1, 16'd2, 1'b1);
    do_clear("plan_bad");

    // Oversized count rejected right after CNT_LO, no writes.
    send_header(16'd65, 1'b0, chk);
    @(negedge clk);
    check("oversize_err", 64'(err), 64'd1);
    check("oversize_ready", 64'(in_ready), 64'd0);
    check("oversize_hold", 64'(cpu_hold), 64'd1);
    @(posedge clk);
    #1;
    do_clear("oversize");

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].n, vecs[v].bad, vecs[v].gaps);
      finish_frame($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err,
                   vecs[v].exp_ww, vecs[v].exp_hold);
      do_clear($sformatf("vec%0d", v));
    end

    // clear during DATA is ignored and the frame completes normally.
    send_header(16'd1, 1'b0, chk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("load_clear_ready", 64'(in_ready), 64'd1);
    check("load_clear_hold", 64'(cpu_hold), 64'd1);
    @(posedge clk);
    #1;
    send_word(32'hDEAD_BEEF, 0, 1'b0, chk);
    send_byte(chk, 1'b0);
    finish_frame("load_clear", 1'b1, 1'b0, 16'd1, 1'b0);
    do_clear("load_clear");

    // rst after the second data byte of the first word.
    send_header(16'd2, 1'b0, chk);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // rst coinciding with the fourth byte: the strobe must never appear.
    send_header(16'd1, 1'b0, chk);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h04;
    rst      = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("drop_we", 64'(mem_we), 64'd0);
    check_reset("droprst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(16'd2, 1'b0, 1'b0);
    finish_frame("after_rst", 1'b1, 1'b0, 16'd2, 1'b0);
    do_clear("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
